// File: rtl/gauss_pwl_interp.sv
// Four-stage piecewise-linear evaluator for h(u) = sqrt(-2 ln u) * 2^11 in the Box-Muller datapath.
// The table ROM sits outside this block; one advance signal moves or holds every stage together.
module gauss_pwl_interp #(
    parameter int IN_W   = 16,
    parameter int ADDR_W = 11,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_x,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr_a,
    output logic [ADDR_W-1:0] rom_addr_b,
    input  logic [OUT_W-1:0]  rom_data_a,
    input  logic [OUT_W-1:0]  rom_data_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_y,
    output logic              out_zero
);

    localparam int FRAC_W = IN_W - ADDR_W;
    localparam int PROD_W = OUT_W + FRAC_W + 2;
    localparam logic [PROD_W-1:0] ROUND_C = PROD_W'(1) << (FRAC_W - 1);

    logic                     w_adv;
    logic [ADDR_W-1:0]        w_addrA;
    logic signed [OUT_W:0]    w_diff;
    logic signed [PROD_W-1:0] w_diffExt;
    logic signed [PROD_W-1:0] w_fracExt;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [OUT_W+1:0]  w_corr;
    logic [FRAC_W-1:0]        w_unusedLo;
    logic signed [OUT_W+1:0]  w_sum;
    logic [OUT_W-1:0]         w_sat;

    logic                     r_s1_v;
    logic [FRAC_W-1:0]        r_s1_frac;
    logic                     r_s1_zero;

    logic                     r_s2_v;
    logic [OUT_W-1:0]         r_s2_h0;
    logic signed [OUT_W:0]    r_s2_diff;
    logic [FRAC_W-1:0]        r_s2_frac;
    logic                     r_s2_zero;

    logic                     r_s3_v;
    logic [OUT_W-1:0]         r_s3_h0;
    logic signed [OUT_W+1:0]  r_s3_corr;
    logic                     r_s3_zero;

    // Global stall: the whole pipe, including the ROM output register, freezes together.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv && reset;
    assign rom_en   = in_valid && in_ready;

    // The top entry pairs with itself so the last segment is flat instead of wrapping to entry 0.
    assign w_addrA    = in_x[IN_W-1:FRAC_W];
    assign rom_addr_a = w_addrA;
    assign rom_addr_b = (&w_addrA) ? w_addrA : w_addrA + ADDR_W'(1);

    assign w_diff    = $signed({1'b0, rom_data_b}) - $signed({1'b0, rom_data_a});
    assign w_diffExt = {{(FRAC_W + 1){r_s2_diff[OUT_W]}}, r_s2_diff};
    assign w_fracExt = {{(OUT_W + 2){1'b0}}, r_s2_frac};
    assign w_prod    = w_diffExt * w_fracExt;

    // Adding half an LSB and dropping the fraction bits gives round-half-up on a signed value.
    assign {w_corr, w_unusedLo} = w_prod + ROUND_C;

    assign w_sum = $signed({2'b00, r_s3_h0}) + r_s3_corr;

    always_comb begin
        w_sat = w_sum[OUT_W-1:0];
        if (w_sum[OUT_W+1]) begin
            w_sat = '0;
        end else if (w_sum[OUT_W]) begin
            w_sat = '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_v    <= 1'b0;
            r_s1_frac <= '0;
            r_s1_zero <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s2_h0   <= '0;
            r_s2_diff <= '0;
            r_s2_frac <= '0;
            r_s2_zero <= 1'b0;
            r_s3_v    <= 1'b0;
            r_s3_h0   <= '0;
            r_s3_corr <= '0;
            r_s3_zero <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_zero  <= 1'b0;
        end else if (w_adv) begin
            r_s1_v    <= in_valid;
            r_s1_frac <= in_x[FRAC_W-1:0];
            r_s1_zero <= (in_x == '0);

            r_s2_v    <= r_s1_v;
            r_s2_h0   <= rom_data_a;
            r_s2_diff <= w_diff;
            r_s2_frac <= r_s1_frac;
            r_s2_zero <= r_s1_zero;

            r_s3_v    <= r_s2_v;
            r_s3_h0   <= r_s2_h0;
            r_s3_corr <= w_corr;
            r_s3_zero <= r_s2_zero;

            out_valid <= r_s3_v;
            out_y     <= r_s3_zero ? '1 : w_sat;
            out_zero  <= r_s3_zero;
        end
    end

endmodule

// File: tb/tb_gauss_pwl_interp.sv
// Scoreboard bench for gauss_pwl_interp: expected results are queued at accept and
// popped when the DUT transfers an output; each test task does its own comparisons.
module tb_gauss_pwl_interp;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic        rom_en;
    logic [10:0] rom_addr_a;
    logic [10:0] rom_addr_b;
    logic [15:0] rom_data_a;
    logic [15:0] rom_data_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic        out_zero;

    logic [15:0] rom [0:2047];
    logic [16:0] sbQ [$];
    int compared   = 0;
    int mismatched = 0;

    gauss_pwl_interp #(.IN_W(16), .ADDR_W(11), .OUT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .rom_en     (rom_en),
        .rom_addr_a (rom_addr_a),
        .rom_addr_b (rom_addr_b),
        .rom_data_a (rom_data_a),
        .rom_data_b (rom_data_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port ROM with one cycle of read latency; data holds while rom_en is low.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_data_a <= rom[rom_addr_a];
            rom_data_b <= rom[rom_addr_b];
        end
    end

    function automatic logic [16:0] model(input logic [15:0] x);
        int idx, a, b, f, corr, sum;
        if (x == 16'd0) return {1'b1, 16'hFFFF};
        idx  = int'(x >> 5);
        f    = int'(x & 16'h001F);
        a    = int'(rom[idx]);
        b    = (idx == 2047) ? a : int'(rom[idx + 1]);
        corr = ((b - a) * f + 16) >>> 5;
        sum  = a + corr;
        if (sum < 0) sum = 0;
        else if (sum > 65535) sum = 65535;
        return {1'b0, sum[15:0]};
    endfunction

    // One clock of stimulus: drive at negedge, sample 1 ns later, record handshakes.
    task automatic stepCycle(input logic v, input logic [15:0] x, input logic rdy,
                             output logic acc, output logic xfer, output logic hadExp,
                             output logic [16:0] obs, output logic [16:0] expV);
        in_valid  = v;
        in_x      = x;
        out_ready = rdy;
        #1;
        acc    = in_valid && in_ready;
        xfer   = out_valid && out_ready;
        obs    = {out_zero, out_y};
        expV   = '0;
        hadExp = 1'b0;
        if (xfer && sbQ.size() > 0) begin
            expV   = sbQ.pop_front();
            hadExp = 1'b1;
        end
        if (acc) sbQ.push_back(model(x));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runSingle(input logic [15:0] x, output int tries, output int lat,
                             output logic got, output logic hadExp,
                             output logic [16:0] obs, output logic [16:0] expV);
        logic acc, xfer;
        acc   = 1'b0;
        got   = 1'b0;
        tries = 0;
        lat   = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            stepCycle(1'b1, x, 1'b1, acc, xfer, hadExp, obs, expV);
            tries++;
        end
        if (!acc) return;
        for (int i = 0; i < 10 && !got; i++) begin
            stepCycle(1'b0, 16'd0, 1'b1, acc, xfer, hadExp, obs, expV);
            lat++;
            if (xfer) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        compared++;
        if (out_y !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_y: got %h expected 0000", out_y); end
        compared++;
        if (out_zero !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_zero: got %b expected 0", out_zero); end
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single(input string name, input logic [15:0] x, input logic [16:0] required);
        int tries, lat;
        logic got, hadExp;
        logic [16:0] obs, expV;
        runSingle(x, tries, lat, got, hadExp, obs, expV);
        compared++;
        if (!got) begin
            mismatched++;
            $display("[TB] FAIL %s_timeout: got no output expected one", name);
            return;
        end
        compared++;
        if (lat !== 4) begin mismatched++; $display("[TB] FAIL %s_latency: got %0d expected 4", name, lat); end
        compared++;
        if (!hadExp || obs !== expV) begin mismatched++; $display("[TB] FAIL %s_model: got %h expected %h", name, obs, expV); end
        compared++;
        if (obs !== required) begin mismatched++; $display("[TB] FAIL %s_value: got %h expected %h", name, obs, required); end
    endtask

    task automatic test_top_boundary();
        in_valid = 1'b0;
        in_x     = 16'hFFFF;
        #1;
        compared++;
        if (rom_addr_a !== 11'd2047) begin mismatched++; $display("[TB] FAIL top_addr_a: got %0d expected 2047", rom_addr_a); end
        compared++;
        if (rom_addr_b !== 11'd2047) begin mismatched++; $display("[TB] FAIL top_addr_b: got %0d expected 2047", rom_addr_b); end
        test_single("top", 16'hFFFF, {1'b0, rom[2047]});
    endtask

    task automatic test_streaming();
        logic [15:0] xs [8];
        logic acc, xfer, hadExp;
        logic [16:0] obs, expV;
        int idx = 0, nOut = 0, firstOut = 0, lastOut = 0, lastAcc = 0;
        for (int i = 0; i < 8; i++) xs[i] = 16'($urandom_range(1, 65535));
        for (int cyc = 0; cyc < 40 && nOut < 8; cyc++) begin
            stepCycle(idx < 8, (idx < 8) ? xs[idx] : 16'd0, 1'b1, acc, xfer, hadExp, obs, expV);
            if (acc) begin idx++; lastAcc = cyc; end
            if (xfer) begin
                if (nOut == 0) firstOut = cyc;
                lastOut = cyc;
                nOut++;
                compared++;
                if (!hadExp || obs !== expV) begin mismatched++; $display("[TB] FAIL stream_data: got %h expected %h", obs, expV); end
            end
        end
        compared++;
        if (lastAcc !== 7) begin mismatched++; $display("[TB] FAIL stream_accept_run: got last accept %0d expected 7", lastAcc); end
        compared++;
        if (nOut !== 8 || lastOut - firstOut !== 7) begin
            mismatched++;
            $display("[TB] FAIL stream_consecutive: got %0d outputs over %0d cycles expected 8 over 8", nOut, lastOut - firstOut + 1);
        end
        compared++;
        if (sbQ.size() !== 0) begin mismatched++; $display("[TB] FAIL stream_leftover: got %0d expected 0", sbQ.size()); end
    endtask

    task automatic test_backpressure();
        logic [15:0] xs [10];
        logic acc, xfer, hadExp, heldZ;
        logic [16:0] obs, expV;
        logic [15:0] heldY;
        int idx = 0, nOut = 0;
        for (int i = 0; i < 10; i++) xs[i] = 16'($urandom_range(1, 65535));
        for (int cyc = 0; cyc < 6; cyc++) begin
            stepCycle(1'b1, xs[idx], 1'b1, acc, xfer, hadExp, obs, expV);
            if (acc) idx++;
            if (xfer) begin
                nOut++;
                compared++;
                if (!hadExp || obs !== expV) begin mismatched++; $display("[TB] FAIL bp_pre_data: got %h expected %h", obs, expV); end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = xs[idx];
        #1;
        heldY = out_y;
        heldZ = out_zero;
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_full: got %b expected 1", out_valid); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            stepCycle(1'b1, xs[idx], 1'b0, acc, xfer, hadExp, obs, expV);
            if (acc) idx++;
            compared++;
            if (in_ready !== 1'b0 || rom_en !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bp_in_ready: got in_ready=%b rom_en=%b expected 0/0", in_ready, rom_en);
            end
            compared++;
            if (out_valid !== 1'b1 || out_y !== heldY || out_zero !== heldZ) begin
                mismatched++;
                $display("[TB] FAIL bp_hold: got %b/%h/%b expected 1/%h/%b", out_valid, out_y, out_zero, heldY, heldZ);
            end
        end
        for (int cyc = 0; cyc < 60 && nOut < 10; cyc++) begin
            stepCycle(idx < 10, (idx < 10) ? xs[idx] : 16'd0, 1'b1, acc, xfer, hadExp, obs, expV);
            if (acc) idx++;
            if (xfer) begin
                nOut++;
                compared++;
                if (!hadExp || obs !== expV) begin mismatched++; $display("[TB] FAIL bp_post_data: got %h expected %h", obs, expV); end
            end
        end
        compared++;
        if (nOut !== 10 || sbQ.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL bp_count: got %0d outputs, %0d pending expected 10, 0", nOut, sbQ.size());
        end
    endtask

    task automatic test_reset_mid();
        logic acc, xfer, hadExp, got;
        logic [16:0] obs, expV;
        int tries, lat;
        for (int i = 0; i < 4; i++) begin
            stepCycle(1'b1, 16'((100 << 5) | (i * 5 + 3)), 1'b1, acc, xfer, hadExp, obs, expV);
        end
        in_valid = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_prefill: got %b expected 1", out_valid); end
        #1;
        reset = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_y !== 16'h0 || out_zero !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_async_clear: got %b/%h/%b expected 0/0000/0", out_valid, out_y, out_zero);
        end
        sbQ.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        runSingle(16'((100 << 5) | 16), tries, lat, got, hadExp, obs, expV);
        compared++;
        if (tries !== 1) begin mismatched++; $display("[TB] FAIL mid_first_accept: got %0d tries expected 1", tries); end
        compared++;
        if (!got || lat !== 4) begin mismatched++; $display("[TB] FAIL mid_latency: got %0d (out=%b) expected 4", lat, got); end
        compared++;
        if (obs !== 17'h03F80 || !hadExp || obs !== expV) begin
            mismatched++;
            $display("[TB] FAIL mid_value: got %h expected 03f80", obs);
        end
    endtask

    task automatic test_saturation();
        logic acc, xfer, hadExp;
        logic [16:0] obs, expV;
        int f = 0, nOut = 0;
        for (int cyc = 0; cyc < 300 && nOut < 32; cyc++) begin
            stepCycle(f < 32, (f < 32) ? 16'((5 << 5) | f) : 16'd0,
                      ($urandom_range(0, 3) != 0), acc, xfer, hadExp, obs, expV);
            if (acc) f++;
            if (xfer) begin
                nOut++;
                compared++;
                if (!hadExp || obs !== expV) begin mismatched++; $display("[TB] FAIL sat_data: got %h expected %h", obs, expV); end
            end
        end
        compared++;
        if (nOut !== 32 || sbQ.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL sat_count: got %0d outputs, %0d pending expected 32, 0", nOut, sbQ.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 16'(60000 - i * 25 + (i % 7) * 3);
        rom[100] = 16'h4000;
        rom[101] = 16'h3F00;
        rom[5]   = 16'hFFF0;
        rom[6]   = 16'h0010;
        rom_data_a = '0;
        rom_data_b = '0;

        test_reset();
        test_single("interp", 16'((100 << 5) | 16), 17'h03F80);
        test_single("frac0", 16'(101 << 5), 17'h03F00);
        test_top_boundary();
        test_single("zero", 16'h0000, 17'h1FFFF);
        test_streaming();
        test_backpressure();
        test_reset_mid();
        test_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
